// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared constants for the registered 4-to-16 select-line decoder.
//   DEC_IN_W    : width of the binary index A
//   DEC_OUT_W   : width of the one-hot select word Y (2**DEC_IN_W)
//   DEC_RESET_Y : value Y takes on every edge that samples reset=1
package decoder_pkg;

   localparam int DEC_IN_W  = 4;
   localparam int DEC_OUT_W = 16;

   localparam logic [DEC_OUT_W-1:0] DEC_RESET_Y = 16'h0000;

endpackage : decoder_pkg

// File: rtl/decoder_4_16_core.sv
// decoder_4_16_core
// Purely combinational binary-to-one-hot decode. Usable standalone
// wherever an unregistered decode is wanted (e.g. ALU control).
// Ports:
//   en     : in  1      1 = decode A, 0 = force next_Y to all zero
//   A      : in  N      binary index
//   next_Y : out 2**N   one-hot select word, or all zero when en=0
module decoder_4_16_core
   import decoder_pkg::*;
#(
   parameter int N = DEC_IN_W
) (
   input  logic              en,
   input  logic [N-1:0]      A,
   output logic [(2**N)-1:0] next_Y
);

   localparam int OUT_W = 2**N;

   // Single set bit at position 0, shifted into place by the index.
   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   always_comb begin
      next_Y = '0;
      if (en) begin
         next_Y = ONE << A;
      end
   end

endmodule : decoder_4_16_core

// File: rtl/decoder_4_16.sv
// decoder_4_16
// Registered 4-to-16 one-hot decoder used as a select-line generator
// (register-file write enables, peripheral selects). The index is
// decoded combinationally and captured on each rising edge so
// downstream logic sees glitch-free, clock-aligned strobes. Latency is
// one cycle; a new index may be applied every cycle.
// Ports:
//   clk   : in  1      system clock, rising-edge active
//   reset : in  1      synchronous active-high reset, wins over en and A
//   en    : in  1      1 = decode A, 0 = all outputs low
//   A     : in  N      binary index, 0..2**N-1
//   Y     : out 2**N   registered one-hot select, or all zero
module decoder_4_16
   import decoder_pkg::*;
#(
   parameter int N = DEC_IN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [N-1:0]      A,
   output logic [(2**N)-1:0] Y
);

   localparam int OUT_W = 2**N;

   logic [OUT_W-1:0] next_Y;

   decoder_4_16_core #(
      .N (N)
   ) u_core (
      .en     (en),
      .A      (A),
      .next_Y (next_Y)
   );

   // Reset and en=0 both yield zero, so the two paths never disagree.
   always_ff @(posedge clk) begin
      if (reset) begin
         Y <= OUT_W'(DEC_RESET_Y);
      end else begin
         Y <= next_Y;
      end
   end

endmodule : decoder_4_16

// File: tb/tb_decoder_4_16.sv
// tb_decoder_4_16
// Table-driven bench for decoder_4_16: each record holds the inputs
// presented before an edge and the Y required just after that edge.
module tb_decoder_4_16;

   typedef struct {
      string       name;
      logic        reset;
      logic        en;
      logic [3:0]  a;
      logic [15:0] exp_y;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  A;
   logic [15:0] Y;

   int n_vec;
   int n_err;

   vec_t vec_q[$];

   decoder_4_16 dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .A     (A),
      .Y     (Y)
   );

   // clock block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input string name, input logic r, input logic e,
                      input logic [3:0] a, input logic [15:0] exp_y);
      vec_t v;
      v.name  = name;
      v.reset = r;
      v.en    = e;
      v.a     = a;
      v.exp_y = exp_y;
      vec_q.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp_y);
      n_vec++;
      if (act !== exp_y) begin
         n_err++;
         $display("FAIL %s: Y=%h required %h", name, act, exp_y);
      end
   endtask

   // Independent structural check: never multi-hot, never X.
   task automatic check_onehot0(input string name, input logic [15:0] act);
      int cnt;
      cnt = 0;
      for (int b = 0; b < 16; b++) if (act[b] === 1'b1) cnt++;
      n_vec++;
      if ($isunknown(act) || cnt > 1) begin
         n_err++;
         $display("FAIL %s_onehot0: Y=%h has %0d bits set", name, act, cnt);
      end
   endtask

   // Drive inputs, cross one rising edge, sample 1 time unit after it.
   task automatic step(input logic r, input logic e, input logic [3:0] a);
      reset = r;
      en    = e;
      A     = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] hold_y;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      en    = 1'b1;
      A     = 4'd7;
      @(negedge clk);

      // reset held two cycles with active inputs
      add("reset0", 1'b1, 1'b1, 4'd7, 16'h0000);
      add("reset1", 1'b1, 1'b1, 4'd7, 16'h0000);
      // full sweep, hand-written expected words
      add("sweep0",  1'b0, 1'b1, 4'd0,  16'h0001);
      add("sweep1",  1'b0, 1'b1, 4'd1,  16'h0002);
      add("sweep2",  1'b0, 1'b1, 4'd2,  16'h0004);
      add("sweep3",  1'b0, 1'b1, 4'd3,  16'h0008);
      add("sweep4",  1'b0, 1'b1, 4'd4,  16'h0010);
      add("sweep5",  1'b0, 1'b1, 4'd5,  16'h0020);
      add("sweep6",  1'b0, 1'b1, 4'd6,  16'h0040);
      add("sweep7",  1'b0, 1'b1, 4'd7,  16'h0080);
      add("sweep8",  1'b0, 1'b1, 4'd8,  16'h0100);
      add("sweep9",  1'b0, 1'b1, 4'd9,  16'h0200);
      add("sweep10", 1'b0, 1'b1, 4'd10, 16'h0400);
      add("sweep11", 1'b0, 1'b1, 4'd11, 16'h0800);
      add("sweep12", 1'b0, 1'b1, 4'd12, 16'h1000);
      add("sweep13", 1'b0, 1'b1, 4'd13, 16'h2000);
      add("sweep14", 1'b0, 1'b1, 4'd14, 16'h4000);
      add("sweep15", 1'b0, 1'b1, 4'd15, 16'h8000);
      // enable
      add("en_on",   1'b0, 1'b1, 4'd5, 16'h0020);
      add("en_off",  1'b0, 1'b0, 4'd5, 16'h0000);
      add("en_back", 1'b0, 1'b1, 4'd5, 16'h0020);
      add("en_off9", 1'b0, 1'b0, 4'd9, 16'h0000);
      // mid-operation reset
      add("mid_pre",   1'b0, 1'b1, 4'd15, 16'h8000);
      add("mid_reset", 1'b1, 1'b1, 4'd15, 16'h0000);
      add("mid_post",  1'b0, 1'b1, 4'd15, 16'h8000);
      // reset together with en=0
      add("rst_en0",   1'b1, 1'b0, 4'd3,  16'h0000);
      add("after_rst", 1'b0, 1'b1, 4'd3,  16'h0008);
      // back-to-back alternation, no bubble
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) add("b2b_lo", 1'b0, 1'b1, 4'd0,  16'h0001);
         else            add("b2b_hi", 1'b0, 1'b1, 4'd15, 16'h8000);
      end

      foreach (vec_q[i]) begin
         step(vec_q[i].reset, vec_q[i].en, vec_q[i].a);
         check(vec_q[i].name, Y, vec_q[i].exp_y);
         check_onehot0(vec_q[i].name, Y);
      end

      // intra-cycle changes: A moves 3 -> 9 -> 12 between edges,
      // Y must hold its prior value until the edge, then show only 12.
      step(1'b0, 1'b1, 4'd1);
      check("intra_pre", Y, 16'h0002);
      hold_y = 16'h0002;
      A = 4'd3;
      #2;
      check("intra_a3", Y, hold_y);
      A = 4'd9;
      #2;
      check("intra_a9", Y, hold_y);
      A = 4'd12;
      @(posedge clk);
      #1;
      check("intra_a12", Y, 16'h1000);
      check_onehot0("intra_a12", Y);

      // en toggled mid-cycle but low at the edge
      en = 1'b1;
      #2;
      en = 1'b0;
      #2;
      check("intra_en_hold", Y, 16'h1000);
      @(posedge clk);
      #1;
      check("intra_en_low", Y, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_decoder_4_16
